placar_shot_display: RTL and testbench

Display and violation end of the scoreboard shot clock. Consumes the 5-bit countdown value from the shot-clock counter, synchronises and debounces it into the system clock domain, and drives a two-digit multiplexed active-low 7-segment display. Detects the nonzero-to-zero transition and raises a timed buzzer pulse and a violation flag until the clock is reloaded.

---
 rtl/placar_shot_display_pkg.sv | 25 ++
 rtl/placar_shot_display_seg7_decoder.sv | 27 ++
 rtl/placar_shot_display.sv | 170 +++++++++++++++++
 tb/tb_placar_shot_display.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/placar_shot_display_pkg.sv
// Shared scoreboard display definitions: shot-clock states, active-low segment codes and limits.
package placar_pkg;

    typedef enum logic [1:0] {
        RUN,
        BUZZ,
        EXPIRED
    } shotState_e;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    localparam logic [4:0] MAX_SHOT  = 5'd24;

endpackage

// File: rtl/placar_shot_display_seg7_decoder.sv
// Combinational BCD digit to active-low gfedcba segments; shared with the game-clock display.
module seg7_decoder
    import placar_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    // Codes above 9 never reach a real digit position, so they fall back to blank.
    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/placar_shot_display.sv
// Shot-clock display: synchronise/filter the countdown, scan two 7-seg digits, flag violations.
// Optional LEADING_ZERO_BLANK_EN blanks a zero tens digit while running.
module placar_shot_display
    import placar_pkg::*;
#(
    parameter int SCAN_DIV    = 50000,
    parameter int BUZZ_CYCLES = 50000000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic       clock,
    input  logic       resetN,
    input  logic [4:0] cronometro,
    output logic [6:0] seg,
    output logic [1:0] digitEn,
    output logic       buzzer,
    output logic       violation
);

    localparam int SCAN_W  = $clog2(SCAN_DIV + 1);
    localparam int BUZZ_W  = $clog2(BUZZ_CYCLES + 1);
    localparam int BLINK_W = $clog2(BLINK_DIV + 1);

    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BUZZ_W-1:0]  BUZZ_LOAD  = BUZZ_W'(BUZZ_CYCLES - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    logic [4:0]         sync1, sync2, stableVal;
    shotState_e         state, nextState;
    logic [BUZZ_W-1:0]  buzzCnt, nextBuzzCnt;
    logic [BLINK_W-1:0] blinkCnt, nextBlinkCnt;
    logic               blinkOn, nextBlinkOn;
    logic               armed, nextArmed;
    logic [SCAN_W-1:0]  scanCnt, nextScanCnt;
    logic               activeDigit, nextDigit;
    logic [3:0]         tensVal, unitsVal, digitVal;
    logic [6:0]         decoded, nextSeg;
    logic               stableNonZero;

    assign stableNonZero = (stableVal != 5'd0);

    // A value is accepted only once both synchroniser stages agree, which drops one-cycle glitches.
    always_ff @(posedge clock) begin
        if (!resetN) begin
            sync1       <= '0;
            sync2       <= '0;
            stableVal   <= '0;
            state       <= RUN;
            buzzCnt     <= '0;
            blinkCnt    <= '0;
            blinkOn     <= 1'b1;
            armed       <= 1'b0;
            scanCnt     <= '0;
            activeDigit <= 1'b0;
        end else begin
            sync1       <= cronometro;
            sync2       <= sync1;
            if (sync1 == sync2)
                stableVal <= sync2;
            state       <= nextState;
            buzzCnt     <= nextBuzzCnt;
            blinkCnt    <= nextBlinkCnt;
            blinkOn     <= nextBlinkOn;
            armed       <= nextArmed;
            scanCnt     <= nextScanCnt;
            activeDigit <= nextDigit;
        end
    end

    // Reload is checked before buzz expiry so a reload on the last buzz cycle wins.
    always_comb begin
        nextState    = state;
        nextBuzzCnt  = buzzCnt;
        nextBlinkCnt = '0;
        nextBlinkOn  = 1'b1;
        case (state)
            RUN: begin
                if (armed && !stableNonZero) begin
                    nextState   = BUZZ;
                    nextBuzzCnt = BUZZ_LOAD;
                end
            end
            BUZZ: begin
                if (stableNonZero)
                    nextState = RUN;
                else if (buzzCnt == '0)
                    nextState = EXPIRED;
                else
                    nextBuzzCnt = buzzCnt - BUZZ_W'(1);
            end
            EXPIRED: begin
                if (stableNonZero) begin
                    nextState = RUN;
                end else if (blinkCnt == BLINK_LAST) begin
                    nextBlinkOn = ~blinkOn;
                end else begin
                    nextBlinkCnt = blinkCnt + BLINK_W'(1);
                    nextBlinkOn  = blinkOn;
                end
            end
            default: nextState = RUN;
        endcase

        nextArmed = armed;
        if (stableNonZero)
            nextArmed = 1'b1;
        else if (nextState == BUZZ && state == RUN)
            nextArmed = 1'b0;

        nextScanCnt = (scanCnt == SCAN_LAST) ? '0 : scanCnt + SCAN_W'(1);
        nextDigit   = (scanCnt == SCAN_LAST) ? ~activeDigit : activeDigit;
    end

    always_comb begin
        tensVal  = 4'd0;
        unitsVal = stableVal[3:0];
        if (stableVal >= 5'd20) begin
            tensVal  = 4'd2;
            unitsVal = 4'(stableVal - 5'd20);
        end else if (stableVal >= 5'd10) begin
            tensVal  = 4'd1;
            unitsVal = 4'(stableVal - 5'd10);
        end
    end

    // Outside RUN the panel shows "00", so only RUN feeds the real digit value into the decoder.
    always_comb begin
        digitVal = 4'd0;
        if (nextState == RUN)
            digitVal = nextDigit ? tensVal : unitsVal;
    end

    seg7_decoder digitDecoder (
        .digit (digitVal),
        .seg   (decoded)
    );

    always_comb begin
        nextSeg = decoded;
        case (nextState)
            RUN: begin
                if (stableVal > MAX_SHOT)
                    nextSeg = SEG_DASH;
`ifdef LEADING_ZERO_BLANK_EN
                else if (nextDigit && tensVal == 4'd0)
                    nextSeg = SEG_BLANK;
`endif
            end
            EXPIRED: begin
                if (!nextBlinkOn)
                    nextSeg = SEG_BLANK;
            end
            default: nextSeg = decoded;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetN) begin
            seg       <= SEG_BLANK;
            digitEn   <= 2'b11;
            buzzer    <= 1'b0;
            violation <= 1'b0;
        end else begin
            seg       <= nextSeg;
            digitEn   <= nextDigit ? 2'b01 : 2'b10;
            buzzer    <= (nextState == BUZZ);
            violation <= (nextState != RUN);
        end
    end

endmodule

// File: tb/tb_placar_shot_display.sv
// Directed scoreboard bench for placar_shot_display with small scan/buzz/blink dividers.
module tb_placar_shot_display;

    localparam int SCAN  = 4;
    localparam int BUZZN = 10;
    localparam int BLINK = 3;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] ZERO_TENS = 7'h7F;
`else
    localparam logic [6:0] ZERO_TENS = 7'h40;
`endif

    typedef struct {
        string      tag;
        logic [6:0] tensSeg;
        logic [6:0] unitsSeg;
        logic       buz;
        logic       vio;
        bit         resetExp;
    } expT;

    logic       clock;
    logic       resetN;
    logic [4:0] cronometro;
    logic [6:0] seg;
    logic [1:0] digitEn;
    logic       buzzer;
    logic       violation;

    expT sb[$];
    int  checks = 0;
    int  errors = 0;
    int  edgeN  = 0;

    placar_shot_display #(
        .SCAN_DIV    (SCAN),
        .BUZZ_CYCLES (BUZZN),
        .BLINK_DIV   (BLINK)
    ) dut (
        .clock      (clock),
        .resetN     (resetN),
        .cronometro (cronometro),
        .seg        (seg),
        .digitEn    (digitEn),
        .buzzer     (buzzer),
        .violation  (violation)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic applyStimulus(input logic rst, input logic [4:0] val);
        resetN     = rst;
        cronometro = val;
    endtask

    task automatic tick();
        @(posedge clock);
        if (resetN) edgeN++;
        else        edgeN = 0;
        #1;
    endtask

    task automatic waitTicks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic cmp(input string name, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h at edge %0d", name, obs, exp, edgeN);
        end
    endtask

    task automatic pushExp(input string tag, input logic [6:0] t, input logic [6:0] u,
                           input logic b, input logic v, input bit rst);
        expT e;
        e.tag = tag; e.tensSeg = t; e.unitsSeg = u; e.buz = b; e.vio = v; e.resetExp = rst;
        sb.push_back(e);
    endtask

    // The scan slot follows the edge count since reset release: SCAN edges per digit, units first.
    task automatic checkOutput();
        expT        e;
        logic [6:0] s;
        logic [1:0] en;
        tick();
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("[TB] FAIL scoreboard empty observed=0 expected=1");
            return;
        end
        e = sb.pop_front();
        if (e.resetExp) begin
            s = 7'h7F; en = 2'b11;
        end else if (((edgeN / SCAN) % 2) == 1) begin
            s = e.tensSeg; en = 2'b01;
        end else begin
            s = e.unitsSeg; en = 2'b10;
        end
        cmp({e.tag, ".seg"},       {1'b0, seg},       {1'b0, s});
        cmp({e.tag, ".digitEn"},   {6'b0, digitEn},   {6'b0, en});
        cmp({e.tag, ".buzzer"},    {7'b0, buzzer},    {7'b0, e.buz});
        cmp({e.tag, ".violation"}, {7'b0, violation}, {7'b0, e.vio});
    endtask

    task automatic expectRun(input string tag, input logic [6:0] t, input logic [6:0] u,
                             input logic b, input logic v, input int n);
        for (int i = 0; i < n; i++) pushExp(tag, t, u, b, v, 1'b0);
        for (int i = 0; i < n; i++) checkOutput();
    endtask

    initial begin
        applyStimulus(1'b0, 5'd0);
        waitTicks(2);
        pushExp("reset", 7'h7F, 7'h7F, 1'b0, 1'b0, 1'b1);
        checkOutput();

        applyStimulus(1'b1, 5'd0);
        expectRun("zeroHeld", ZERO_TENS, 7'h40, 1'b0, 1'b0, 100);

        applyStimulus(1'b1, 5'd24);
        waitTicks(3);
        expectRun("max24", 7'h24, 7'h19, 1'b0, 1'b0, 12);

        applyStimulus(1'b1, 5'd1);
        waitTicks(3);
        expectRun("one", ZERO_TENS, 7'h79, 1'b0, 1'b0, 4);

        applyStimulus(1'b1, 5'd0);
        waitTicks(3);
        expectRun("buzz",    7'h40, 7'h40, 1'b1, 1'b1, BUZZN);
        expectRun("expOn1",  7'h40, 7'h40, 1'b0, 1'b1, BLINK);
        expectRun("expOff1", 7'h7F, 7'h7F, 1'b0, 1'b1, BLINK);
        expectRun("expOn2",  7'h40, 7'h40, 1'b0, 1'b1, BLINK);
        expectRun("expOff2", 7'h7F, 7'h7F, 1'b0, 1'b1, BLINK);

        applyStimulus(1'b1, 5'd14);
        waitTicks(3);
        expectRun("reload14", 7'h79, 7'h19, 1'b0, 1'b0, 4);

        applyStimulus(1'b1, 5'd0);
        waitTicks(3);
        expectRun("buzz2", 7'h40, 7'h40, 1'b1, 1'b1, 3);
        applyStimulus(1'b1, 5'd14);
        expectRun("buzzHold",    7'h40, 7'h40, 1'b1, 1'b1, 3);
        expectRun("interrupt14", 7'h79, 7'h19, 1'b0, 1'b0, 6);

        applyStimulus(1'b1, 5'd5);
        waitTicks(3);
        expectRun("five", ZERO_TENS, 7'h12, 1'b0, 1'b0, 4);

        applyStimulus(1'b1, 5'd0);
        expectRun("glitchZero", ZERO_TENS, 7'h12, 1'b0, 1'b0, 1);
        applyStimulus(1'b1, 5'd5);
        expectRun("glitchZero", ZERO_TENS, 7'h12, 1'b0, 1'b0, 8);

        applyStimulus(1'b1, 5'd7);
        expectRun("glitchSeven", ZERO_TENS, 7'h12, 1'b0, 1'b0, 1);
        applyStimulus(1'b1, 5'd5);
        expectRun("glitchSeven", ZERO_TENS, 7'h12, 1'b0, 1'b0, 8);

        applyStimulus(1'b1, 5'd31);
        waitTicks(3);
        expectRun("dash31", 7'h3F, 7'h3F, 1'b0, 1'b0, 8);

        applyStimulus(1'b1, 5'd3);
        waitTicks(3);
        expectRun("three", ZERO_TENS, 7'h30, 1'b0, 1'b0, 2);
        applyStimulus(1'b1, 5'd0);
        waitTicks(3);
        expectRun("buzz3", 7'h40, 7'h40, 1'b1, 1'b1, 2);

        applyStimulus(1'b0, 5'd0);
        pushExp("midBuzzReset", 7'h7F, 7'h7F, 1'b0, 1'b0, 1'b1);
        checkOutput();
        applyStimulus(1'b1, 5'd0);
        expectRun("postReset", ZERO_TENS, 7'h40, 1'b0, 1'b0, 30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
